// File: rtl/quad_decoder4_pkg.sv
// Shared definitions for the quad_decoder4 quadrature decoder.
// Optional feature macro: QDEC_GLITCH_FILTER_EN (adds a 2-sample glitch filter).
package quad_decoder4_pkg;

    // Gray states in forward (count-up) order: S0 -> S1 -> S2 -> S3 -> S0
    localparam logic [1:0] QDEC_S0 = 2'b00;
    localparam logic [1:0] QDEC_S1 = 2'b01;
    localparam logic [1:0] QDEC_S2 = 2'b11;
    localparam logic [1:0] QDEC_S3 = 2'b10;

    localparam logic QDEC_DIR_UP = 1'b1;
    localparam logic QDEC_DIR_DN = 1'b0;

    // Extra cycles the optional filter adds to latency and to the priming window
`ifdef QDEC_GLITCH_FILTER_EN
    localparam int unsigned QDEC_FILT_CYCLES = 1;
`else
    localparam int unsigned QDEC_FILT_CYCLES = 0;
`endif

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } qdec_state_e;

    // Successor of a Gray state in the forward direction
    function automatic logic [1:0] qdec_fwd(input logic [1:0] s);
        logic [1:0] nxt;
        case (s)
            QDEC_S0: nxt = QDEC_S1;
            QDEC_S1: nxt = QDEC_S2;
            QDEC_S2: nxt = QDEC_S3;
            default: nxt = QDEC_S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_decoder4_sync_ff.sv
// Single-bit synchroniser chain (the sync_ff stage), DEPTH flops, reset to 0.
module quad_decoder4_sync_ff #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain_q;
    logic [DEPTH-1:0] chain_d;

    // Shift the asynchronous input one stage deeper each cycle
    always_comb begin
        chain_d = {chain_q[DEPTH-2:0], d};
    end

    // Chain register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/quad_decoder4.sv
// Quadrature A/B decoder: synchronises both phases, decodes Gray transitions
// into up/down steps, keeps a wrapping position count and flags illegal jumps.
// Optional feature macro: QDEC_GLITCH_FILTER_EN (pair must be stable for 2 samples).
module quad_decoder4 #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] pos,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic             err_sticky
);
    import quad_decoder4_pkg::*;

    localparam int unsigned PRIME_LEN = SYNC_STAGES + 1 + QDEC_FILT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(PRIME_LEN);

    logic       a_s;
    logic       b_s;
    logic [1:0] sync_pair;
    logic [1:0] cur_c;
    logic [1:0] diff_c;

    quad_decoder4_sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_ff_a (
        .clk (clk),
        .rst (arst),
        .d   (a),
        .q   (a_s)
    );

    quad_decoder4_sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_ff_b (
        .clk (clk),
        .rst (arst),
        .d   (b),
        .q   (b_s)
    );

    assign sync_pair = {a_s, b_s};

`ifdef QDEC_GLITCH_FILTER_EN
    logic [1:0] samp_q, samp_d;
    logic [1:0] hold_q, hold_d;

    // Accept the synchronised pair only once it matches the previous sample
    always_comb begin
        samp_d = sync_pair;
        hold_d = hold_q;
        if (sync_pair == samp_q) begin
            hold_d = sync_pair;
        end
    end

    // Filter sample and accepted-value registers
    always_ff @(posedge clk) begin
        if (arst) begin
            samp_q <= 2'b00;
            hold_q <= 2'b00;
        end else begin
            samp_q <= samp_d;
            hold_q <= hold_d;
        end
    end

    assign cur_c = hold_d;
`else
    assign cur_c = sync_pair;
`endif

    qdec_state_e      state_q, state_d;
    logic [CNT_W-1:0] prime_cnt_q, prime_cnt_d;
    logic [1:0]       prev_q, prev_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;

    assign diff_c = cur_c ^ prev_q;

    // PRIME/RUN sequencing and Gray-transition decode
    always_comb begin
        state_d      = state_q;
        prime_cnt_d  = prime_cnt_q;
        prev_d       = cur_c;
        pos_d        = pos_q;
        dir_d        = dir_q;
        step_d       = 1'b0;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;

        case (state_q)
            ST_PRIME: begin
                if (prime_cnt_q == CNT_W'(PRIME_LEN - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    prime_cnt_d = prime_cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (en && (diff_c != 2'b00)) begin
                    if (diff_c == 2'b11) begin
                        err_d        = 1'b1;
                        err_sticky_d = 1'b1;
                    end else if (cur_c == qdec_fwd(prev_q)) begin
                        pos_d  = pos_q + WIDTH'(1);
                        dir_d  = QDEC_DIR_UP;
                        step_d = 1'b1;
                    end else begin
                        pos_d  = pos_q - WIDTH'(1);
                        dir_d  = QDEC_DIR_DN;
                        step_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_PRIME;
            end
        endcase
    end

    // State, history and registered outputs; reset overrides any decode
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q      <= ST_PRIME;
            prime_cnt_q  <= '0;
            prev_q       <= 2'b00;
            pos_q        <= '0;
            dir_q        <= QDEC_DIR_UP;
            step_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prime_cnt_q  <= prime_cnt_d;
            prev_q       <= prev_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign pos        = pos_q;
    assign dir        = dir_q;
    assign step       = step_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;

endmodule
